// File: rtl/base5_pkg.sv
// Package for the streaming radix-5 digit generator.
// Holds the FSM state encoding and the constants shared by the top level and
// the divide-by-5 core.
package base5_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int DIV_CONST      = 5;
    localparam int DIGIT_W        = 3;
    localparam int DEFAULT_DIGITS = 7;

endpackage

// File: rtl/div_16_5.sv
// Combinational constant divider: q = x / 5, r = x % 5 for a 16-bit unsigned x.
// No registers inside.
//
// Ports
//   x  in  16  unsigned dividend
//   q  out 16  quotient
//   r  out 3   remainder, always 0..4
module div_16_5
    import base5_pkg::*;
(
    input  logic [15:0]        x,
    output logic [15:0]        q,
    output logic [DIGIT_W-1:0] r
);

    // Reciprocal multiply: 52429 / 2^18 slightly exceeds 1/5. The error term is
    // below 0.05 for any 16-bit x, and x/5 has a fractional part of at most 0.8,
    // so the floor is exact. The product fits in 32 bits.
    localparam logic [31:0] RECIP = 32'd52429;

    always_comb begin
        q = 16'((32'(x) * RECIP) >> 18);
        r = DIGIT_W'(x - q * 16'(DIV_CONST));
    end

endmodule

// File: rtl/base5_digit_gen.sv
// Streaming radix-5 converter. Accepts a W-bit unsigned word over valid/ready,
// repeatedly divides it by 5 (one division per CALC pass) and emits the
// base-5 digits least-significant first over valid/ready, with a last flag.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        in_x is valid
//   in_ready   out  1        word can be accepted (IDLE only)
//   in_x       in   W        unsigned dividend
//   out_valid  out  1        out_digit is valid
//   out_ready  in   1        consumer accepts the digit
//   out_digit  out  3        base-5 digit 0..4
//   out_idx    out  IDX_W    digit position, 0 = least significant
//   out_last   out  1        final digit of the current word
//
// Build option
//   B5_LEADING_ZERO_SUPPRESS_EN: when defined, a word ends as soon as the
//   remaining quotient is zero (X=0 still emits one digit). When undefined,
//   every word emits exactly DIGITS digits, zero-padded at the top.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an input word, in_ready=1
// CALC  | one division of V by 5; register digit/idx/last, raise out_valid
// EMIT  | digit held on the output until out_ready; then next digit or IDLE
module base5_digit_gen
    import base5_pkg::*;
#(
    parameter int W      = 16,
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int IDX_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT_W-1:0] out_digit,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             state, state_nxt;
    logic [W-1:0]       v, v_nxt;
    logic [IDX_W-1:0]   cnt, cnt_nxt;
    logic               out_valid_nxt;
    logic [DIGIT_W-1:0] out_digit_nxt;
    logic [IDX_W-1:0]   out_idx_nxt;
    logic               out_last_nxt;

    logic [15:0]        q;
    logic [DIGIT_W-1:0] r;
    logic               q_zero;

    div_16_5 u_div (
        .x (v),
        .q (q),
        .r (r)
    );

    assign q_zero   = (q == '0);
    assign in_ready = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        v_nxt         = v;
        cnt_nxt       = cnt;
        out_valid_nxt = out_valid;
        out_digit_nxt = out_digit;
        out_idx_nxt   = out_idx;
        out_last_nxt  = out_last;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    v_nxt     = in_x;
                    cnt_nxt   = '0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                out_digit_nxt = r;
                out_idx_nxt   = cnt;
                v_nxt         = W'(q);
`ifdef B5_LEADING_ZERO_SUPPRESS_EN
                out_last_nxt  = (cnt == LAST_IDX) || q_zero;
`else
                out_last_nxt  = (cnt == LAST_IDX);
`endif
                out_valid_nxt = 1'b1;
                state_nxt     = EMIT;
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (out_last) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = CALC;
                    end
                end
            end
            default: begin
                out_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            v         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_digit <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            v         <= v_nxt;
            cnt       <= cnt_nxt;
            out_valid <= out_valid_nxt;
            out_digit <= out_digit_nxt;
            out_idx   <= out_idx_nxt;
            out_last  <= out_last_nxt;
        end
    end

`ifndef B5_LEADING_ZERO_SUPPRESS_EN
    // Only consulted when leading-zero suppression is built in.
    logic unused_q_zero;
    assign unused_q_zero = q_zero;
`endif

endmodule
